// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: requester drives start/a/b,
// the adder returns status, sum and flags.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zr;
  logic             ng;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout, ovf, zr, ng
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout, ovf, zr, ng
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: one registered full-adder slice, LSB first,
// WIDTH processing cycles per addition with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);

  localparam int COUNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             r_state, r_state_next;
  logic [WIDTH-1:0]   r_op_a, r_op_a_next;
  logic [WIDTH-1:0]   r_op_b, r_op_b_next;
  logic [WIDTH-1:0]   r_psum, r_psum_next;
  logic               r_carry, r_carry_next;
  logic [COUNT_W-1:0] r_count, r_count_next;
  logic [WIDTH-1:0]   r_sum, r_sum_next;
  logic               r_cout, r_cout_next;
  logic               r_ovf, r_ovf_next;
  logic               r_zr, r_zr_next;
  logic               r_ng, r_ng_next;
  logic               r_done, r_done_next;

  logic               w_s;
  logic               w_c;
  logic               w_last;
  logic [WIDTH-1:0]   w_psum_shift;

  // Full-adder slice on the current LSBs and the carry flop
  assign w_s          = r_op_a[0] ^ r_op_b[0] ^ r_carry;
  assign w_c          = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);
  assign w_last       = (r_count == COUNT_W'(WIDTH - 1));
  assign w_psum_shift = {w_s, r_psum[WIDTH-1:1]};

  always_comb begin
    r_state_next = r_state;
    r_op_a_next  = r_op_a;
    r_op_b_next  = r_op_b;
    r_psum_next  = r_psum;
    r_carry_next = r_carry;
    r_count_next = r_count;
    r_sum_next   = r_sum;
    r_cout_next  = r_cout;
    r_ovf_next   = r_ovf;
    r_zr_next    = r_zr;
    r_ng_next    = r_ng;
    r_done_next  = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          r_state_next = RUN;
          r_op_a_next  = bus.a;
          r_op_b_next  = bus.b;
          r_psum_next  = '0;
          r_carry_next = 1'b0;
          r_count_next = '0;
        end
      end
      RUN: begin
        r_op_a_next  = r_op_a >> 1;
        r_op_b_next  = r_op_b >> 1;
        r_psum_next  = w_psum_shift;
        r_carry_next = w_c;
        r_count_next = r_count + COUNT_W'(1);
        if (w_last) begin
          // r_carry still holds the carry into the MSB on this edge
          r_state_next = IDLE;
          r_count_next = '0;
          r_sum_next   = w_psum_shift;
          r_cout_next  = w_c;
          r_ovf_next   = r_carry ^ w_c;
          r_zr_next    = (w_psum_shift == '0);
          r_ng_next    = w_s;
          r_done_next  = 1'b1;
        end
      end
      default: r_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zr    <= 1'b0;
      r_ng    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= r_state_next;
      r_op_a  <= r_op_a_next;
      r_op_b  <= r_op_b_next;
      r_psum  <= r_psum_next;
      r_carry <= r_carry_next;
      r_count <= r_count_next;
      r_sum   <= r_sum_next;
      r_cout  <= r_cout_next;
      r_ovf   <= r_ovf_next;
      r_zr    <= r_zr_next;
      r_ng    <= r_ng_next;
      r_done  <= r_done_next;
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.zr   = r_zr;
  assign bus.ng   = r_ng;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=16): latency, flags,
// ignored start, back-to-back accept and mid-operation reset.
module tb_serial_adder;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  serial_adder_if #(.WIDTH(16)) bus ();

  serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Ends at the negedge following the accept edge
  task automatic launch(input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = va;
    bus.b     = vb;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts negedges until done is seen (bounded), and busy cycles on the way
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b, expected 0/0", bus.busy, bus.done);
    end
    checks++;
    if (bus.sum !== 16'h0000 || {bus.cout, bus.ovf, bus.zr, bus.ng} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_result: sum=%h flags=%b, expected 0000/0000", bus.sum,
               {bus.cout, bus.ovf, bus.zr, bus.ng});
    end
    $display("reset: busy=%b done=%b sum=%h", bus.busy, bus.done, bus.sum);
  endtask

  task automatic test_basic();
    int n, bc;
    launch(16'h0001, 16'h0001);
    wait_done(n, bc);
    checks++;
    if (n != 16 || bc != 16) begin
      errors++;
      $display("FAIL basic_latency: cycles=%0d busy=%0d, expected 16/16", n, bc);
    end
    checks++;
    if (bus.sum !== 16'h0002) begin
      errors++;
      $display("FAIL basic_sum: got %h expected 0002", bus.sum);
    end
    checks++;
    if ({bus.cout, bus.ovf, bus.zr, bus.ng} !== 4'b0000) begin
      errors++;
      $display("FAIL basic_flags: got %b expected 0000", {bus.cout, bus.ovf, bus.zr, bus.ng});
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: done=%b busy=%b after pulse, expected 0/0", bus.done, bus.busy);
    end
    $display("basic: 0001+0001 sum=%h cycles=%0d", bus.sum, n);
  endtask

  task automatic test_wrap();
    int n, bc;
    launch(16'hFFFF, 16'h0001);
    wait_done(n, bc);
    checks++;
    if (n != 16 || bus.sum !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_sum: got %h after %0d cycles, expected 0000 after 16", bus.sum, n);
    end
    checks++;
    if ({bus.cout, bus.ovf, bus.zr, bus.ng} !== 4'b1010) begin
      errors++;
      $display("FAIL wrap_flags: got %b expected 1010", {bus.cout, bus.ovf, bus.zr, bus.ng});
    end
    $display("wrap: FFFF+0001 sum=%h cout=%b zr=%b", bus.sum, bus.cout, bus.zr);
  endtask

  task automatic test_signed_ovf();
    int n, bc;
    launch(16'h7FFF, 16'h0001);
    wait_done(n, bc);
    checks++;
    if (n != 16 || bus.sum !== 16'h8000) begin
      errors++;
      $display("FAIL sovf_sum: got %h after %0d cycles, expected 8000 after 16", bus.sum, n);
    end
    checks++;
    if ({bus.cout, bus.ovf, bus.zr, bus.ng} !== 4'b0101) begin
      errors++;
      $display("FAIL sovf_flags: got %b expected 0101", {bus.cout, bus.ovf, bus.zr, bus.ng});
    end
    $display("signed_ovf: 7FFF+0001 sum=%h ovf=%b ng=%b", bus.sum, bus.ovf, bus.ng);
  endtask

  task automatic test_min_neg();
    int n, bc;
    launch(16'h8000, 16'h8000);
    wait_done(n, bc);
    checks++;
    if (n != 16 || bus.sum !== 16'h0000 || {bus.cout, bus.ovf, bus.zr, bus.ng} !== 4'b1110) begin
      errors++;
      $display("FAIL minneg: sum=%h flags=%b cycles=%0d, expected 0000/1110/16", bus.sum,
               {bus.cout, bus.ovf, bus.zr, bus.ng}, n);
    end
    $display("min_neg: 8000+8000 sum=%h flags=%b", bus.sum, {bus.cout, bus.ovf, bus.zr, bus.ng});
  endtask

  task automatic test_ignored_start();
    int n, bc, extra_done;
    launch(16'h0003, 16'h0004);
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      bus.a     = 16'hFFFF - 16'(i);
      bus.b     = 16'hAAAA + 16'(i);
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.sum !== 16'h8000) begin
      errors++;
      $display("FAIL ign_hold: busy=%b sum=%h mid-op, expected 1/8000", bus.busy, bus.sum);
    end
    wait_done(n, bc);
    checks++;
    if (n != 11 || bus.sum !== 16'h0007 || {bus.cout, bus.ovf, bus.zr, bus.ng} !== 4'b0000) begin
      errors++;
      $display("FAIL ign_result: sum=%h flags=%b cycles=%0d, expected 0007/0000/11", bus.sum,
               {bus.cout, bus.ovf, bus.zr, bus.ng}, n);
    end
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin
      errors++;
      $display("FAIL ign_no_second: %0d cycles with done/busy, expected 0", extra_done);
    end
    $display("ignored_start: 0003+0004 sum=%h", bus.sum);
  endtask

  task automatic test_back_to_back();
    int n, bc;
    launch(16'h00FF, 16'h0001);
    wait_done(n, bc);
    checks++;
    if (n != 16 || bus.sum !== 16'h0100) begin
      errors++;
      $display("FAIL b2b_first: sum=%h cycles=%0d, expected 0100/16", bus.sum, n);
    end
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h4321;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.sum !== 16'h0100) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b sum=%h, expected 1/0/0100", bus.busy, bus.done,
               bus.sum);
    end
    wait_done(n, bc);
    checks++;
    if (n != 16 || bc != 16 || bus.sum !== 16'h5555 ||
        {bus.cout, bus.ovf, bus.zr, bus.ng} !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_second: sum=%h flags=%b cycles=%0d busy=%0d, expected 5555/0000/16/16",
               bus.sum, {bus.cout, bus.ovf, bus.zr, bus.ng}, n, bc);
    end
    $display("back_to_back: 00FF+0001 then 1234+4321 sum=%h", bus.sum);
  endtask

  task automatic test_mid_reset();
    int seen;
    launch(16'h1111, 16'h2222);
    repeat (7) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.sum !== 16'h5555) begin
      errors++;
      $display("FAIL mrst_before: busy=%b sum=%h, expected 1/5555", bus.busy, bus.sum);
    end
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = 16'h0F0F;
    bus.b     = 16'h0101;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 16'h0000 ||
        {bus.cout, bus.ovf, bus.zr, bus.ng} !== 4'b0000) begin
      errors++;
      $display("FAIL mrst_clear: busy=%b done=%b sum=%h flags=%b, expected 0/0/0000/0000",
               bus.busy, bus.done, bus.sum, {bus.cout, bus.ovf, bus.zr, bus.ng});
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mrst_no_done: %0d cycles with done/busy, expected 0", seen);
    end
    $display("mid_reset: aborted 1111+2222, sum=%h busy=%b", bus.sum, bus.busy);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_signed_ovf();
    test_ignored_start();
    test_min_neg();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
